// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared types and grant helpers for the round-robin arbiter-mux
// Helpers work on MAX_N-wide vectors so callers of any N up to MAX_N can share them.
package rr_arb_pkg;

  localparam int MAX_N     = 32;
  localparam int MAX_IDX_W = 5;

  typedef logic [MAX_N-1:0]     chan_vec_t;
  typedef logic [MAX_IDX_W-1:0] chan_idx_t;

  // OR of the indices of all set bits; exact for one-hot input, no priority chain.
  function automatic chan_idx_t onehot_to_idx(input chan_vec_t oh);
    chan_idx_t idx;
    idx = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (oh[i[MAX_IDX_W-1:0]]) idx = idx | chan_idx_t'(i);
    end
    return idx;
  endfunction

  function automatic chan_vec_t rotate_first_set(input chan_vec_t req, input chan_idx_t ptr,
                                                 input int n);
    chan_vec_t grant;
    logic      found;
    int        j;
    chan_idx_t jj;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_N; k++) begin
      j = int'(ptr) + k;
      if (j >= n) j = j - n;
      jj = j[MAX_IDX_W-1:0];
      if (k < n && !found && req[jj]) begin
        grant[jj] = 1'b1;
        found     = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/rr_arb_mux_if.sv
// rtl/rr_arb_mux_if.sv - N-channel request side plus single output stream of the arbiter-mux
interface rr_arb_mux_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
);

  logic [N-1:0]     in_valid;
  logic [WIDTH-1:0] in_data [N-1:0];
  logic [N-1:0]     in_last;
  logic [N-1:0]     in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic [N-1:0]     out_sel;
  logic [IDX_W-1:0] out_idx;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_sel, out_idx
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_sel, out_idx
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant generator with optional packet lock
// Owns the rotating pointer and, in packet mode, the channel lock held until a last beat.
module rr_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N           = 4,
  parameter int PACKET_MODE = 0,
  parameter int IDX_W       = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic [N-1:0] last,
  input  logic         advance,
  output logic [N-1:0] grant
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] lock_ch;
  logic             lock;
  logic [N-1:0]     rr_grant;
  logic [N-1:0]     lock_grant;
  logic [IDX_W-1:0] g;
  logic [IDX_W-1:0] ptr_next;

  assign rr_grant   = N'(rotate_first_set(chan_vec_t'(req), chan_idx_t'(ptr), N));
  // A locked channel that drops valid leaves a bubble rather than letting others in.
  assign lock_grant = N'(chan_vec_t'(1) << lock_ch) & req;
  assign grant      = (PACKET_MODE != 0 && lock) ? lock_grant : rr_grant;

  assign g        = IDX_W'(onehot_to_idx(chan_vec_t'(grant)));
  assign ptr_next = (g == IDX_W'(N - 1)) ? '0 : g + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= '0;
      lock    <= 1'b0;
      lock_ch <= '0;
    end else if (advance) begin
      if (PACKET_MODE == 0) begin
        ptr <= ptr_next;
      end else if (last[g]) begin
        ptr  <= ptr_next;
        lock <= 1'b0;
      end else begin
        lock    <= 1'b1;
        lock_ch <= g;
      end
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// rtl/rr_arb_mux.sv - N-channel round-robin arbiter with AND-OR data mux and one output register
// A new beat loads on the same edge the held beat drains, so full throughput is sustained.
module rr_arb_mux
  import rr_arb_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int N           = 4,
  parameter int PACKET_MODE = 0,
  parameter int IDX_W       = (N > 1) ? $clog2(N) : 1
) (
  input logic          clk,
  input logic          rst,
  rr_arb_mux_if.slave  bus
);

  logic [N-1:0]     grant;
  logic             can_load;
  logic             accept;
  logic [IDX_W-1:0] g;
  logic [WIDTH-1:0] acc_data [N+1];
  logic             acc_last [N+1];

  rr_arbiter #(
    .N           (N),
    .PACKET_MODE (PACKET_MODE),
    .IDX_W       (IDX_W)
  ) u_arbiter (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.in_valid),
    .last    (bus.in_last),
    .advance (accept),
    .grant   (grant)
  );

  assign can_load     = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = grant & {N{can_load}};
  assign accept       = |(bus.in_valid & bus.in_ready);
  assign g            = IDX_W'(onehot_to_idx(chan_vec_t'(grant)));

  // One-hot AND-OR chain: at most one term is non-zero, so no priority is implied.
  assign acc_data[0] = '0;
  assign acc_last[0] = 1'b0;
  for (genvar i = 0; i < N; i++) begin : g_mux
    assign acc_data[i+1] = acc_data[i] | (bus.in_data[i] & {WIDTH{grant[i]}});
    assign acc_last[i+1] = acc_last[i] | (bus.in_last[i] & grant[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
      bus.out_sel   <= '0;
      bus.out_idx   <= '0;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= acc_data[N];
      bus.out_last  <= (PACKET_MODE != 0) ? acc_last[N] : 1'b1;
      bus.out_sel   <= grant;
      bus.out_idx   <= g;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(bus.in_ready) && $onehot0(bus.out_sel));
    end
  end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- N-channel valid/ready arbiter-multiplexer.
- A round-robin arbiter selects one active input channel per cycle; that channel's data is steered through a one-hot AND-OR mux into a single registered output stage.
- Optional packet mode holds the grant on one channel until its last beat.
- Sits between multiple producer queues and one shared downstream consumer, such as a memory or host channel.

Parameters:
- WIDTH, 32, data bits per channel.
- N, 4, number of input channels (N >= 1).
- PACKET_MODE, 0, 1 = grant held from first beat until in_last beat accepted; 0 = re-arbitrate every beat.
- IDX_W, $clog2(N) (min 1), width of the binary channel index.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  N  per-channel beat valid.
- in_data  in  N x WIDTH  per-channel data, unpacked array [N-1:0].
- in_last  in  N  per-channel end-of-packet; ignored when PACKET_MODE=0.
- in_ready  out  N  per-channel accept; at most one bit set.
- out_valid  out  1  output register holds a beat.
- out_ready  in  1  downstream accept.
- out_data  out  WIDTH  selected data.
- out_last  out  1  last flag of the held beat.
- out_sel  out  N  one-hot source channel of the held beat.
- out_idx  out  IDX_W  binary source channel of the held beat.

Behaviour:
- Reset values (clk edge with rst=1): out_valid=0, out_data=0, out_last=0, out_sel=0, out_idx=0, priority pointer=0, lock=0.
- A reset mid-packet drops the lock and any held beat.
- can_load = ~out_valid | out_ready. This is full-throughput pass-through: a beat is accepted on the same cycle the held beat drains.
- Arbitration is combinational. Among channels with in_valid=1, the grant goes to the first channel at or after the pointer, searching upward and wrapping at N-1 to 0.
- in_ready[i] = grant[i] & can_load. in_ready does not depend on in_valid of other channels beyond the grant computation.
- Accept when in_valid[g] & in_ready[g]. On the next clk:
  - out_valid=1
  - out_data=in_data[g]
  - out_last = in_last[g] if PACKET_MODE, else 1
  - out_sel=grant
  - out_idx=g
- Latency: input to output is exactly 1 cycle.
- If out_valid & out_ready and there is no accept: out_valid goes to 0 and the data registers hold their values.
- If out_valid & ~out_ready: all output registers hold and in_ready=0 on every channel.
- Pointer update, PACKET_MODE=0: on each accept from channel g, pointer = (g+1) mod N.
- Pointer update, PACKET_MODE=1: the pointer advances only on accept with in_last[g]=1.
- Pointer when idle: with no accept, the pointer is unchanged, including when no channel is valid.
- Lock (PACKET_MODE=1):
  - An accept with in_last=0 sets lock=1 and lock_ch=g.
  - While locked, grant=onehot(lock_ch) regardless of other valids. If in_valid[lock_ch]=0, no channel is granted (bubble), and other channels must not be served.
  - An accept with in_last=1 clears the lock.
  - A single-beat packet (last on first beat) never sets the lock.
- No valid inputs: grant=0, in_ready=0.
- N=1: grant = in_valid[0]; the pointer stays 0.
- Invariant: $onehot0(in_ready) and $onehot0(out_sel) in every cycle.

Decomposition:
- Package rr_arb_pkg holds:
  - function onehot_to_idx (N-generic, priority-free OR of indices)
  - function rotate_first_set(req, ptr) returning a one-hot grant
- Sub-module rr_arbiter (N, PACKET_MODE) contains:
  - inputs: clk, rst, req, last, advance
  - outputs: one-hot grant
  - owns the pointer, lock and lock_ch registers
- The top level holds the AND-OR data mux, the can_load logic and the output register stage.

Test Plan:
- Single channel, basic transfer: after reset, in_valid=0001, in_data[0]=aaaa_aaaa, out_ready=1. Expect in_ready=0001; next cycle out_valid=1, out_data=aaaa_aaaa, out_sel=0001, out_idx=0.
- Round-robin fairness (PACKET_MODE=0): all 4 valid, data aaaa/bbbb/cccc/dddd repeated, out_ready=1 for 8 cycles. Expect out_idx sequence 0,1,2,3,0,1,2,3 and no bubbles.
- Backpressure: out_ready=0 for 3 cycles with channels 1 and 2 valid. Expect out_data to hold bbbb_bbbb and in_ready=0000. Release out_ready: next beat is cccc_cccc with out_idx=2.
- Packet lock (PACKET_MODE=1): ch0 sends 3 beats with last on the 3rd, while ch1 is valid throughout and ch0 deasserts valid for 1 cycle mid-packet. Expect out_idx 0,0,(bubble),0 then 1; ch1 in_ready=0 until ch0's last beat is accepted.
- Reset mid-packet: assert rst for 1 cycle during a locked ch2 packet. Expect all outputs 0 and lock cleared; next grant goes to the lowest valid channel from pointer 0.
- Sparse and wrap: only ch3 valid, then only ch0 valid. Expect grants 1000 then 0001; the pointer wraps from 3 to 0 and no idle cycle is inserted.
